stage_id: RTL

Instruction-decode stage of the MIPS pipeline, directly downstream of the instruction-fetch stage. It consumes the 32-bit instruction word that fetch produces each cycle and returns jump control and jump address to fetch combinationally. It holds the 32x32 register file, which is written from write-back. It decodes the supported opcode subset into control bits and registers operands plus control into the ID/EX pipeline register, which supports stall and flush.

---
 rtl/stage_id.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/stage_id.sv
// MIPS instruction-decode stage: register file, decoder and ID/EX register.
// Optional STAGE_ID_BYPASS_EN forwards same-cycle write-back data to the read ports.
module stage_id #(
    parameter logic [31:0] RESET_REG_VALUE = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        control_stall,
    input  logic        control_flush,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_reg_addr,
    input  logic [31:0] wb_data,
    output logic        control_is_jump,
    output logic [31:0] data_jump_address,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_alu_src,
    output logic        ex_reg_dst,
    output logic        ex_mem_to_reg,
    output logic        ex_branch_eq,
    output logic [3:0]  ex_alu_op
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       branch_eq;
        logic [3:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
    } id_ex_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rf_q [32];
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    ctrl_t       ctrl_d;
    id_ex_t      id_ex_d;
    id_ex_t      id_ex_q;

    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];

    assign control_is_jump   = (opcode == 6'b000010);
    assign data_jump_address = {6'b0, instruction[25:0]};

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_q[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                rf_q[i] <= RESET_REG_VALUE;
            end
        end else if (wb_reg_write && (wb_reg_addr != 5'd0)) begin
            rf_q[wb_reg_addr] <= wb_data;
        end
    end

    always_comb begin
        rs_data = rf_q[rs];
        rt_data = rf_q[rt];
`ifdef STAGE_ID_BYPASS_EN
        if (wb_reg_write && (wb_reg_addr == rs)) begin
            rs_data = wb_data;
        end
        if (wb_reg_write && (wb_reg_addr == rt)) begin
            rt_data = wb_data;
        end
`endif
        if (rs == 5'd0) begin
            rs_data = '0;
        end
        if (rt == 5'd0) begin
            rt_data = '0;
        end
    end

    always_comb begin
        ctrl_d = '0;
        case (opcode)
            6'b000000: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
                case (funct)
                    6'b100000: ctrl_d.alu_op = ALU_ADD;
                    6'b100010: ctrl_d.alu_op = ALU_SUB;
                    6'b100100: ctrl_d.alu_op = ALU_AND;
                    6'b100101: ctrl_d.alu_op = ALU_OR;
                    6'b101010: ctrl_d.alu_op = ALU_SLT;
                    default:   ctrl_d = '0;
                endcase
            end
            6'b100011: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.alu_op     = ALU_ADD;
            end
            6'b101011: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_op    = ALU_ADD;
            end
            6'b000100: begin
                ctrl_d.branch_eq = 1'b1;
                ctrl_d.alu_op    = ALU_SUB;
            end
            6'b001000: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_op    = ALU_ADD;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_comb begin
        id_ex_d         = '0;
        id_ex_d.ctrl    = ctrl_d;
        id_ex_d.rs      = rs;
        id_ex_d.rt      = rt;
        id_ex_d.rd      = instruction[15:11];
        id_ex_d.rs_data = rs_data;
        id_ex_d.rt_data = rt_data;
        id_ex_d.imm     = {{16{instruction[15]}}, instruction[15:0]};
    end

    // Flush outranks stall so a squashed slot never survives a hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_ex_q <= '0;
        end else if (control_flush) begin
            id_ex_q <= '0;
        end else if (!control_stall) begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ex_rs_data    = id_ex_q.rs_data;
    assign ex_rt_data    = id_ex_q.rt_data;
    assign ex_imm        = id_ex_q.imm;
    assign ex_rs         = id_ex_q.rs;
    assign ex_rt         = id_ex_q.rt;
    assign ex_rd         = id_ex_q.rd;
    assign ex_reg_write  = id_ex_q.ctrl.reg_write;
    assign ex_mem_read   = id_ex_q.ctrl.mem_read;
    assign ex_mem_write  = id_ex_q.ctrl.mem_write;
    assign ex_alu_src    = id_ex_q.ctrl.alu_src;
    assign ex_reg_dst    = id_ex_q.ctrl.reg_dst;
    assign ex_mem_to_reg = id_ex_q.ctrl.mem_to_reg;
    assign ex_branch_eq  = id_ex_q.ctrl.branch_eq;
    assign ex_alu_op     = id_ex_q.ctrl.alu_op;

endmodule
